// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter giving one core per cycle a load or store on a single memory port,
// with a fixed-latency, in-order load-return pipeline.
module mem_port_arbiter #(
    parameter int NCORES = 4,
    parameter int RD_LAT = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCORES-1:0]    req_ld,
    input  logic [NCORES-1:0]    req_st,
    input  logic [NCORES*16-1:0] req_addr,
    input  logic [NCORES*16-1:0] req_wdata,
    output logic [NCORES-1:0]    gnt,
    output logic                 gnt_st,
    output logic [NCORES-1:0]    rd_valid,
    output logic [15:0]          rd_data,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [15:0]          mem_addr,
    output logic [15:0]          mem_wdata,
    input  logic [15:0]          mem_rdata
);
    localparam int IW = (NCORES > 1) ? $clog2(NCORES) : 1;

    logic [IW-1:0]     rr_q, rr_d, win, idx;
    logic [NCORES-1:0] st_done_q, st_done_d, st_eff, pend, ld_gnt;
    logic              found, is_st;
    logic [RD_LAT-1:0] pv_q;
    logic [IW-1:0]     pid_q [RD_LAT];

    // A core whose store was already granted while its load is still held competes only with the load.
    assign st_eff = req_st & ~st_done_q;
    assign pend   = rst_n ? (req_ld | st_eff) : '0;

    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int i = 0; i < NCORES; i++) begin
            idx = IW'((int'(rr_q) + i) % NCORES);
            if (!found && pend[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        is_st     = found && st_eff[win];
        gnt       = found ? (NCORES'(1) << win) : '0;
        gnt_st    = is_st;
        ld_gnt    = (found && !is_st) ? gnt : '0;
        mem_en    = found;
        mem_we    = is_st;
        mem_addr  = found ? req_addr[int'(win)*16 +: 16] : '0;
        mem_wdata = is_st ? req_wdata[int'(win)*16 +: 16] : '0;
        rr_d      = found ? ((int'(win) == NCORES-1) ? '0 : win + 1'b1) : rr_q;
        st_done_d = (st_done_q | (is_st ? gnt : '0)) & ~ld_gnt & req_ld & req_st;
        rd_valid  = pv_q[RD_LAT-1] ? (NCORES'(1) << pid_q[RD_LAT-1]) : '0;
        rd_data   = pv_q[RD_LAT-1] ? mem_rdata : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q      <= '0;
            st_done_q <= '0;
            pv_q      <= '0;
            for (int i = 0; i < RD_LAT; i++) pid_q[i] <= '0;
        end else begin
            rr_q      <= rr_d;
            st_done_q <= st_done_d;
            pv_q[0]   <= found && !is_st;
            pid_q[0]  <= win;
            for (int i = 1; i < RD_LAT; i++) begin
                pv_q[i]  <= pv_q[i-1];
                pid_q[i] <= pid_q[i-1];
            end
        end
    end
endmodule
